activation_unit: RTL and testbench

- Downstream consumer of the accumulator register file: takes one row of MATRIX_WIDTH 32-bit accumulator words per beat.
- Per lane: requantizes each word (rounding arithmetic right shift), applies the selected activation function, and saturates to one byte.
- Emits a byte row plus its unified-buffer write address for the buffer write port.
- Fixed 3-stage pipeline with a valid bit and a global stall.

---
 rtl/activation_unit.sv | 155 +++++++++++++++
 tb/tb_activation_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_unit.sv
// Requantize, activate and byte-saturate one accumulator row per beat.
// Optional ACT_SAT_COUNT_EN adds a sticky count of saturating beats.
module activation_unit #(
    parameter int MATRIX_WIDTH      = 14,
    parameter int BUFFER_ADDR_WIDTH = 24,
    parameter int RELU6_MAX         = 96
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         valid_in,
    input  logic [32*MATRIX_WIDTH-1:0]   data_in,
    input  logic                         signed_mode,
    input  logic [4:0]                   shift,
    input  logic [1:0]                   act_func,
    input  logic [BUFFER_ADDR_WIDTH-1:0] buffer_addr_in,
    output logic                         valid_out,
    output logic [8*MATRIX_WIDTH-1:0]    data_out,
    output logic [BUFFER_ADDR_WIDTH-1:0] buffer_addr_out
`ifdef ACT_SAT_COUNT_EN
    ,
    output logic [31:0]                  sat_count
`endif
);

    localparam logic [1:0] ACT_RELU  = 2'b01;
    localparam logic [1:0] ACT_RELU6 = 2'b10;
    localparam logic signed [33:0] RELU6_CLIP = 34'(RELU6_MAX);

    function automatic logic signed [33:0] requant(
        input logic [31:0] w, input logic sm, input logic [4:0] sh);
        logic signed [33:0] ext;
        logic signed [33:0] rnd;
        ext = {{2{sm & w[31]}}, w};
        rnd = (sh == 5'd0) ? 34'sd0 : (34'sd1 <<< (sh - 5'd1));
        return (ext + rnd) >>> sh;
    endfunction

    function automatic logic signed [33:0] activate(
        input logic signed [33:0] v, input logic [1:0] af);
        logic signed [33:0] a;
        a = v;
        unique case (1'b1)
            (af == ACT_RELU): begin
                if (v < 34'sd0) a = '0;
            end
            (af == ACT_RELU6): begin
                if (v < 34'sd0) a = '0;
                else if (v > RELU6_CLIP) a = RELU6_CLIP;
            end
            default: a = v;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] saturate(
        input logic signed [33:0] a, input logic sm);
        if (sm) begin
            if (a > 34'sd127) return 8'h7F;
            if (a < -34'sd128) return 8'h80;
        end else begin
            if (a > 34'sd255) return 8'hFF;
            if (a < 34'sd0) return 8'h00;
        end
        return a[7:0];
    endfunction

    logic                         s1_valid;
    logic [32*MATRIX_WIDTH-1:0]   s1_data;
    logic                         s1_signed;
    logic [4:0]                   s1_shift;
    logic [1:0]                   s1_act;
    logic [BUFFER_ADDR_WIDTH-1:0] s1_addr;

    logic                         s2_valid;
    logic [34*MATRIX_WIDTH-1:0]   s2_val;
    logic                         s2_signed;
    logic [1:0]                   s2_act;
    logic [BUFFER_ADDR_WIDTH-1:0] s2_addr;

    logic [34*MATRIX_WIDTH-1:0]   req_val;
    logic [8*MATRIX_WIDTH-1:0]    next_data;
    logic signed [33:0]           act_v [MATRIX_WIDTH];

    always_comb begin
        req_val = '0;
        for (int i = 0; i < MATRIX_WIDTH; i++)
            req_val[34*i +: 34] = requant(s1_data[32*i +: 32], s1_signed, s1_shift);
    end

    always_comb begin
        next_data = '0;
        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            act_v[i] = activate(s2_val[34*i +: 34], s2_act);
            next_data[8*i +: 8] = saturate(act_v[i], s2_signed);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_signed <= 1'b0;
            s1_shift  <= '0;
            s1_act    <= '0;
            s1_addr   <= '0;
            s2_valid  <= 1'b0;
            s2_val    <= '0;
            s2_signed <= 1'b0;
            s2_act    <= '0;
            s2_addr   <= '0;
            valid_out       <= 1'b0;
            data_out        <= '0;
            buffer_addr_out <= '0;
        end else if (enable) begin
            s1_valid  <= valid_in;
            s1_data   <= data_in;
            s1_signed <= signed_mode;
            s1_shift  <= shift;
            s1_act    <= act_func;
            s1_addr   <= buffer_addr_in;
            s2_valid  <= s1_valid;
            s2_val    <= req_val;
            s2_signed <= s1_signed;
            s2_act    <= s1_act;
            s2_addr   <= s1_addr;
            valid_out       <= s2_valid;
            data_out        <= next_data;
            buffer_addr_out <= s2_addr;
        end
    end

`ifdef ACT_SAT_COUNT_EN
    // Only the final byte clamp counts; RELU6 clipping lands inside range.
    logic [MATRIX_WIDTH-1:0] lane_sat;

    always_comb begin
        lane_sat = '0;
        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            if (s2_signed)
                lane_sat[i] = (act_v[i] > 34'sd127) || (act_v[i] < -34'sd128);
            else
                lane_sat[i] = (act_v[i] > 34'sd255) || (act_v[i] < 34'sd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_count <= '0;
        else if (enable && s2_valid && (|lane_sat) && (sat_count != '1))
            sat_count <= sat_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_activation_unit.sv
// Directed and random checks of activation_unit against an arithmetic
// reference model with a three-beat delay line.
module tb_activation_unit;

    localparam int MW = 14;
    localparam int AW = 24;
    localparam int R6 = 96;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b1;
    logic              valid_in = 1'b0;
    logic [32*MW-1:0]  data_in = '0;
    logic              signed_mode = 1'b1;
    logic [4:0]        shift = '0;
    logic [1:0]        act_func = '0;
    logic [AW-1:0]     buffer_addr_in = '0;
    logic              valid_out;
    logic [8*MW-1:0]   data_out;
    logic [AW-1:0]     buffer_addr_out;
`ifdef ACT_SAT_COUNT_EN
    logic [31:0]       sat_count;
`endif

    activation_unit #(
        .MATRIX_WIDTH(MW),
        .BUFFER_ADDR_WIDTH(AW),
        .RELU6_MAX(R6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .valid_in(valid_in),
        .data_in(data_in),
        .signed_mode(signed_mode),
        .shift(shift),
        .act_func(act_func),
        .buffer_addr_in(buffer_addr_in),
        .valid_out(valid_out),
        .data_out(data_out),
        .buffer_addr_out(buffer_addr_out)
`ifdef ACT_SAT_COUNT_EN
        ,
        .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0]     lanes [MW];
    bit              m_v [3];
    bit              m_s [3];
    logic [8*MW-1:0] m_d [3];
    logic [AW-1:0]   m_a [3];
    logic [31:0]     ref_sat = 0;
    logic [AW-1:0]   obs_addr [$];

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on one lane.
    function automatic logic [7:0] ref_lane(input logic [31:0] w, input bit sm,
                                            input int sh, input int af,
                                            output bit sat);
        longint x;
        longint lo;
        longint hi;
        x = sm ? longint'($signed(w)) : longint'(w);
        if (sh > 0) x = (x + (longint'(1) << (sh - 1))) >>> sh;
        if (af == 1 && x < 0) x = 0;
        if (af == 2) begin
            if (x < 0) x = 0;
            if (x > R6) x = R6;
        end
        lo = sm ? -128 : 0;
        hi = sm ? 127 : 255;
        sat = 0;
        if (x > hi) begin x = hi; sat = 1; end
        if (x < lo) begin x = lo; sat = 1; end
        return x[7:0];
    endfunction

    function automatic logic [8*MW-1:0] ref_row(output bit any_sat);
        logic [8*MW-1:0] r;
        bit s;
        r = '0;
        any_sat = 0;
        for (int i = 0; i < MW; i++) begin
            r[8*i +: 8] = ref_lane(data_in[32*i +: 32], signed_mode,
                                   int'(shift), int'(act_func), s);
            any_sat |= s;
        end
        return r;
    endfunction

    task automatic tick();
        bit s;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i] = 0; m_s[i] = 0; m_d[i] = '0; m_a[i] = '0;
            end
            ref_sat = 0;
        end else if (enable) begin
            if (m_v[1] && m_s[1] && ref_sat != 32'hFFFF_FFFF) ref_sat++;
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_s[i] = m_s[i-1];
                m_d[i] = m_d[i-1]; m_a[i] = m_a[i-1];
            end
            m_d[0] = ref_row(s);
            m_v[0] = valid_in;
            m_s[0] = s;
            m_a[0] = buffer_addr_in;
        end
        #1;
        check("valid_out", 128'(valid_out), 128'(m_v[2]));
        if (m_v[2]) begin
            check("data_out", 128'(data_out), 128'(m_d[2]));
            check("addr_out", 128'(buffer_addr_out), 128'(m_a[2]));
            obs_addr.push_back(buffer_addr_out);
        end
`ifdef ACT_SAT_COUNT_EN
        check("sat_count", 128'(sat_count), 128'(ref_sat));
`endif
    endtask

    task automatic drive(input bit v, input bit sm, input int sh, input int af,
                         input int addr);
        valid_in = v;
        signed_mode = sm;
        shift = sh[4:0];
        act_func = af[1:0];
        buffer_addr_in = addr[AW-1:0];
        for (int i = 0; i < MW; i++) data_in[32*i +: 32] = lanes[i];
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        for (int i = 0; i < MW; i++) lanes[i] = 32'd0;
        lanes[0] = a; lanes[1] = b; lanes[2] = c; lanes[3] = d;
    endtask

    task automatic run_one();
        tick();
        valid_in = 1'b0;
        tick();
        tick();
    endtask

    logic [8*MW-1:0] row5;
    logic [8*MW-1:0] frz_d;
    logic [AW-1:0]   frz_a;
    logic            frz_v;

    initial begin
        for (int i = 0; i < MW; i++) lanes[i] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_s[i] = 0; m_d[i] = '0; m_a[i] = '0;
        end

        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", 128'(valid_out), 128'(0));
        check("rst_data", 128'(data_out), 128'(0));
        check("rst_addr", 128'(buffer_addr_out), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < MW; i++) lanes[i] = 32'd5;
        drive(1, 1, 0, 0, 'h10);
        tick();
        valid_in = 1'b0;
        check("lat_c1", 128'(valid_out), 128'(0));
        tick();
        check("lat_c2", 128'(valid_out), 128'(0));
        tick();
        for (int i = 0; i < MW; i++) row5[8*i +: 8] = 8'h05;
        check("lat_valid", 128'(valid_out), 128'(1));
        check("lat_data", 128'(data_out), 128'(row5));
        check("lat_addr", 128'(buffer_addr_out), 128'(24'h10));
        tick();
        check("lat_after", 128'(valid_out), 128'(0));

        fill(32'd6, 32'd7, -32'sd6, -32'sd7);
        drive(1, 1, 2, 0, 'h20);
        run_one();
        check("round_s2", 128'(data_out[31:0]), 128'(32'hFEFF_0202));
        for (int i = 0; i < MW; i++) lanes[i] = 32'h7FFF_FFFF;
        drive(1, 1, 31, 0, 'h21);
        run_one();
        check("round_s31", 128'(data_out[7:0]), 128'(8'h01));

        fill(-32'sd50, 32'd40, 32'd200, -32'sd200);
        drive(1, 1, 0, 0, 'h30);
        run_one();
        check("act_none", 128'(data_out[31:0]), 128'(32'h807F_28CE));
        drive(1, 1, 0, 1, 'h31);
        run_one();
        check("act_relu", 128'(data_out[31:0]), 128'(32'h007F_2800));
        drive(1, 1, 0, 2, 'h32);
        run_one();
        check("act_relu6", 128'(data_out[31:0]), 128'(32'h0060_2800));

        fill(32'hFFFF_FFFF, 32'd255, 32'd256, 32'd0);
        drive(1, 0, 0, 3, 'h40);
        run_one();
        check("uns_sat", 128'(data_out[31:0]), 128'(32'h00FF_FFFF));
        fill(32'h0000_0FF8, 32'd0, 32'd0, 32'd0);
        drive(1, 0, 4, 0, 'h41);
        run_one();
        check("uns_shift4", 128'(data_out[7:0]), 128'(8'hFF));

        obs_addr.delete();
        for (int i = 0; i < MW; i++) lanes[i] = $urandom;
        drive(1, 1, 3, 2, 'hA0);
        tick();
        for (int i = 0; i < MW; i++) lanes[i] = $urandom;
        drive(1, 0, 5, 1, 'hA1);
        tick();
        frz_v = valid_out; frz_d = data_out; frz_a = buffer_addr_out;
        enable = 1'b0;
        for (int i = 0; i < MW; i++) lanes[i] = $urandom;
        drive(1, 1, 1, 0, 'hEE);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_v", 128'(valid_out), 128'(frz_v));
            check("stall_d", 128'(data_out), 128'(frz_d));
            check("stall_a", 128'(buffer_addr_out), 128'(frz_a));
        end
        enable = 1'b1;
        drive(1, 1, 0, 0, 'hA2);
        tick();
        for (int i = 0; i < MW; i++) lanes[i] = $urandom;
        drive(1, 1, 7, 0, 'hA3);
        tick();
        valid_in = 1'b0;
        tick(); tick(); tick();
        check("order_cnt", 128'(obs_addr.size()), 128'(4));
        for (int k = 0; k < 4 && k < obs_addr.size(); k++)
            check("order_addr", 128'(obs_addr[k]), 128'(24'hA0 + k));

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < MW; i++) begin
                case ($urandom_range(0, 2))
                    0: lanes[i] = $urandom;
                    1: lanes[i] = 32'($urandom_range(0, 600)) - 32'd300;
                    default: lanes[i] = 32'($urandom_range(0, 4000));
                endcase
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31) > 20 ? $urandom_range(0, 31)
                                             : $urandom_range(0, 4),
                  $urandom_range(0, 3), $urandom_range(0, 24'hFFFFFF));
            enable = $urandom_range(0, 9) != 0;
            tick();
        end
        enable = 1'b1;

        for (int i = 0; i < MW; i++) lanes[i] = 32'd1000;
        drive(1, 1, 0, 0, 'h50);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid_in = 1'b0;
`ifdef ACT_SAT_COUNT_EN
        check("sat_zero", 128'(sat_count), 128'(0));
`endif
        obs_addr.delete();
        tick(); tick(); tick(); tick();
        check("flush_none", 128'(obs_addr.size()), 128'(0));
        drive(1, 1, 0, 0, 'h55);
        tick();
        valid_in = 1'b0;
        tick();
        check("post_c2", 128'(valid_out), 128'(0));
        tick();
        check("post_valid", 128'(valid_out), 128'(1));
        check("post_addr", 128'(buffer_addr_out), 128'(24'h55));
        check("post_lane0", 128'(data_out[7:0]), 128'(8'h7F));
`ifdef ACT_SAT_COUNT_EN
        check("sat_one", 128'(sat_count), 128'(1));
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
